// File: rtl/lcd_char_engine.sv
// lcd_char_engine: HD44780-compatible character LCD engine.
// Keeps a ROWS x COLS frame buffer, runs the power-on init sequence and
// pushes only the rows that have been written since their last flush.
module lcd_char_engine #(
    parameter  int CYCLES_PER_US = 50,
    parameter  int ROWS          = 2,
    parameter  int COLS          = 16,
    parameter  int BUS_WIDTH     = 4,
    parameter  int AUTO_REFRESH  = 0,
    localparam int RW            = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW            = $clog2(COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [RW-1:0]        wr_row,
    input  logic [CW-1:0]        wr_col,
    input  logic [7:0]           wr_char,
    output logic                 wr_err,
    input  logic                 lcd_valid,
    output logic                 lcd_ready,
    output logic [BUS_WIDTH-1:0] lcd_data,
    output logic                 lcd_e,
    output logic                 lcd_rs,
    output logic                 lcd_rw
);

    // All delays are kept as "cycles minus one" so a counter reaching zero
    // marks the last cycle of the interval.
    localparam int PWR_CYC = 15000 * CYCLES_PER_US;
    localparam int TW      = $clog2(PWR_CYC + 1);

    localparam logic [TW-1:0] T_US   = TW'(CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_PWR  = TW'(PWR_CYC - 1);
    localparam logic [TW-1:0] T_4100 = TW'(4100 * CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_100  = TW'(100 * CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_40   = TW'(40 * CYCLES_PER_US - 1);
    localparam logic [TW-1:0] T_1640 = TW'(1640 * CYCLES_PER_US - 1);

    // Function-set byte depends on bus width and on single/multi line mode.
    localparam logic [7:0] FUNC_SET = (BUS_WIDTH == 8) ?
                                      ((ROWS == 1) ? 8'h30 : 8'h38) :
                                      ((ROWS == 1) ? 8'h20 : 8'h28);
    localparam bit          TWO_PART = (BUS_WIDTH == 4);
    localparam logic [CW:0] COL_END  = (CW + 1)'(COLS);

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        ROW_ADDR,
        ROW_CHARS
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_STROBE,
        PH_HOLD,
        PH_SETTLE
    } phase_t;

    state_t                 r_state;
    phase_t                 r_phase;
    logic [TW-1:0]          r_timer;
    logic [3:0]             r_step;
    logic [7:0]             r_txByte;
    logic                   r_txLow;
    logic [TW-1:0]          r_txSettle;
    logic [RW-1:0]          r_row;
    logic [CW:0]            r_col;
    logic [ROWS-1:0]        r_snap;
    logic [ROWS-1:0]        r_dirty;
    logic                   r_ready;
    logic                   r_lcdE;
    logic                   r_lcdRs;
    logic [BUS_WIDTH-1:0]   r_lcdData;
    logic                   r_wrErr;
    logic [7:0]             r_buf [ROWS][COLS];

    logic                   w_txFree;
    logic                   w_selValid;
    logic [RW-1:0]          w_selRow;
    logic                   w_launch;
    logic [7:0]             w_lByte;
    logic                   w_lRs;
    logic                   w_lTwo;
    logic [TW-1:0]          w_lSettle;
    logic                   w_wrOk;
    logic [ROWS-1:0]        w_setMask;
    logic [ROWS-1:0]        w_clrMask;
    logic [CW-1:0]          w_colIdx;
    logic                   w_accept;

    // First bus unit of a byte: the whole byte on an 8-bit bus, the high nibble on a 4-bit bus.
    function automatic logic [BUS_WIDTH-1:0] hiUnit(input logic [7:0] b);
        if (BUS_WIDTH == 8) return BUS_WIDTH'(b);
        else                return BUS_WIDTH'(b[7:4]);
    endfunction

    function automatic logic [BUS_WIDTH-1:0] loUnit(input logic [7:0] b);
        return BUS_WIDTH'(b[3:0]);
    endfunction

    // DDRAM start address of each display line.
    function automatic logic [7:0] rowBase(input logic [RW-1:0] r);
        int ri;
        ri = int'(r);
        case (ri)
            0:       return 8'h00;
            1:       return 8'h40;
            2:       return 8'(COLS);
            default: return 8'(64 + COLS);
        endcase
    endfunction

    assign w_txFree   = (r_phase == PH_IDLE) || ((r_phase == PH_SETTLE) && (r_timer == '0));
    assign w_selValid = (r_state == ROW_ADDR) && w_txFree && (|r_snap);
    assign w_wrOk     = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign w_colIdx   = r_col[CW-1:0];
    assign w_accept   = (r_state == IDLE) &&
                        ((lcd_valid && r_ready) || ((AUTO_REFRESH != 0) && (|r_dirty)));

    // Pick the lowest-numbered row still pending in this pass.
    always_comb begin
        w_selRow = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (r_snap[i]) w_selRow = RW'(i);
        end
    end

    // Dirty-bit set/clear masks; a host write and a row selection may hit the same row in one cycle.
    always_comb begin
        w_setMask = '0;
        w_clrMask = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (wr_en && w_wrOk && (wr_row == RW'(i))) w_setMask[i] = 1'b1;
            if (w_selValid && (w_selRow == RW'(i)))    w_clrMask[i] = 1'b1;
        end
    end

    // Decide which byte (if any) the bus engine should start next.
    always_comb begin
        w_launch  = 1'b0;
        w_lByte   = 8'h00;
        w_lRs     = 1'b0;
        w_lTwo    = 1'b0;
        w_lSettle = T_40;
        case (r_state)
            INIT: begin
                if (w_txFree && (r_step < 4'd8)) begin
                    w_launch = 1'b1;
                    w_lTwo   = TWO_PART && (r_step >= 4'd4);
                    case (r_step)
                        4'd0:    begin w_lByte = 8'h30;    w_lSettle = T_4100; end
                        4'd1:    begin w_lByte = 8'h30;    w_lSettle = T_100;  end
                        4'd2:    w_lByte = 8'h30;
                        4'd3:    w_lByte = 8'h20;
                        4'd4:    w_lByte = FUNC_SET;
                        4'd5:    w_lByte = 8'h0C;
                        4'd6:    begin w_lByte = 8'h01;    w_lSettle = T_1640; end
                        default: w_lByte = 8'h06;
                    endcase
                end
            end
            ROW_ADDR: begin
                if (w_selValid) begin
                    w_launch = 1'b1;
                    w_lByte  = 8'h80 | rowBase(w_selRow);
                    w_lTwo   = TWO_PART;
                end
            end
            ROW_CHARS: begin
                if (w_txFree && (r_col != COL_END)) begin
                    w_launch = 1'b1;
                    w_lByte  = r_buf[r_row][w_colIdx];
                    w_lRs    = 1'b1;
                    w_lTwo   = TWO_PART;
                end
            end
            default: ;
        endcase
    end

    // Frame buffer, dirty flags and write-error pulse; writes are accepted in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_buf[r][c] <= 8'h20;
                end
            end
            r_dirty <= '0;
            r_wrErr <= 1'b0;
        end else begin
            r_wrErr <= wr_en && !w_wrOk;
            if (wr_en && w_wrOk) r_buf[wr_row][wr_col] <= wr_char;
            r_dirty <= (r_dirty & ~w_clrMask) | w_setMask;
        end
    end

    // Control FSM and the setup/strobe/hold/settle bus engine with registered LCD pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= PWR_WAIT;
            r_phase    <= PH_IDLE;
            r_timer    <= T_PWR;
            r_step     <= '0;
            r_txByte   <= '0;
            r_txLow    <= 1'b0;
            r_txSettle <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_snap     <= '0;
            r_ready    <= 1'b0;
            r_lcdE     <= 1'b0;
            r_lcdRs    <= 1'b0;
            r_lcdData  <= '0;
        end else begin
            case (r_phase)
                PH_SETUP: begin
                    if (r_timer == '0) begin
                        r_lcdE  <= 1'b1;
                        r_phase <= PH_STROBE;
                        r_timer <= T_US;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                PH_STROBE: begin
                    if (r_timer == '0) begin
                        r_lcdE  <= 1'b0;
                        r_phase <= PH_HOLD;
                        r_timer <= T_US;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (r_timer == '0) begin
                        if (r_txLow) begin
                            r_lcdData <= loUnit(r_txByte);
                            r_txLow   <= 1'b0;
                            r_phase   <= PH_SETUP;
                            r_timer   <= T_US;
                        end else begin
                            r_phase <= PH_SETTLE;
                            r_timer <= r_txSettle;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                PH_SETTLE: begin
                    if (r_timer == '0) r_phase <= PH_IDLE;
                    else               r_timer <= r_timer - 1'b1;
                end
                default: ;
            endcase

            if (w_launch) begin
                r_phase    <= PH_SETUP;
                r_timer    <= T_US;
                r_lcdData  <= hiUnit(w_lByte);
                r_lcdRs    <= w_lRs;
                r_txByte   <= w_lByte;
                r_txLow    <= w_lTwo;
                r_txSettle <= w_lSettle;
            end

            case (r_state)
                PWR_WAIT: begin
                    if (r_timer == '0) begin
                        r_state <= INIT;
                        r_step  <= '0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                INIT: begin
                    if (w_launch) begin
                        r_step <= ((BUS_WIDTH == 8) && (r_step == 4'd2)) ? 4'd4 : r_step + 1'b1;
                    end else if (w_txFree) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_accept) begin
                        r_snap  <= r_dirty;
                        r_ready <= 1'b0;
                        r_state <= ROW_ADDR;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ROW_ADDR: begin
                    if (w_txFree) begin
                        if (|r_snap) begin
                            r_snap  <= r_snap & ~w_clrMask;
                            r_row   <= w_selRow;
                            r_col   <= '0;
                            r_state <= ROW_CHARS;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                ROW_CHARS: begin
                    if (w_txFree) begin
                        if (r_col == COL_END) r_state <= ROW_ADDR;
                        else                  r_col   <= r_col + 1'b1;
                    end
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

    assign lcd_data  = r_lcdData;
    assign lcd_e     = r_lcdE;
    assign lcd_rs    = r_lcdRs;
    assign lcd_rw    = 1'b0;
    assign lcd_ready = r_ready;
    assign wr_err    = r_wrErr;

endmodule
